dcache_flush_unit: RTL and testbench

- Responder side of the controller's dcache flush handshake (flush request level in, single-cycle acknowledge out).
- Sits inside the write-back dcache. On a flush request it walks every set and issues a write-back for each valid dirty way, then invalidates the set.
- When the last set is done it pulses flush_ack_o. While it is active, busy_o tells the cache to stall miss and refill handling.

---
 rtl/dcache_flush_unit.sv | 146 ++++++++++++++
 tb/tb_dcache_flush_unit.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_flush_unit.sv
// Flush walker for the write-back dcache: visits every set, writes back valid+dirty ways,
// invalidates the set, then acks. Optional stats counters under `DCACHE_FLUSH_STATS_EN.
module dcache_flush_unit #(
    parameter int NUM_SETS     = 256,
    parameter int NUM_WAYS     = 8,
    parameter int TAG_WIDTH    = 44,
    parameter int OFFSET_WIDTH = 4,
    localparam int IDX_W       = $clog2(NUM_SETS),
    localparam int WAY_W       = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
    localparam int ADDR_W      = TAG_WIDTH + IDX_W + OFFSET_WIDTH
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    output logic                          flush_ack_o,
    output logic                          busy_o,
    output logic                          tag_req_o,
    input  logic                          tag_gnt_i,
    output logic [IDX_W-1:0]              tag_idx_o,
    input  logic [NUM_WAYS*TAG_WIDTH-1:0] tag_rdata_i,
    input  logic [NUM_WAYS-1:0]           valid_i,
    input  logic [NUM_WAYS-1:0]           dirty_i,
    output logic                          wb_valid_o,
    input  logic                          wb_ready_i,
    output logic [ADDR_W-1:0]             wb_addr_o,
    output logic [WAY_W-1:0]              wb_way_o,
    output logic                          inv_o
`ifdef DCACHE_FLUSH_STATS_EN
    ,
    output logic [31:0]                   flush_cnt_o,
    output logic [31:0]                   wb_cnt_o
`endif
);

    typedef enum logic [2:0] {
        IDLE, READ, LOOKUP, WB, INV, DONE, DRAIN
    } state_e;

    state_e                          state_q, state_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [NUM_WAYS*TAG_WIDTH-1:0]   tags_q, tags_d;
    logic [NUM_WAYS-1:0]             pend_q, pend_d;
    logic [NUM_WAYS-1:0]             way_oh;
    logic [WAY_W-1:0]                wb_way;

    // Lowest pending way first: one-hot for clearing, encoded for the address/way outputs.
    assign way_oh = pend_q & (~pend_q + NUM_WAYS'(1));

    always_comb begin
        wb_way = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (pend_q[i]) wb_way = WAY_W'(i);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            tags_q  <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tags_q  <= tags_d;
            pend_q  <= pend_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        tags_d      = tags_q;
        pend_d      = pend_q;
        flush_ack_o = 1'b0;
        tag_req_o   = 1'b0;
        wb_valid_o  = 1'b0;
        wb_addr_o   = '0;
        wb_way_o    = '0;
        inv_o       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (flush_i) begin
                    state_d = READ;
                    idx_d   = '0;
                end
            end
            READ: begin
                tag_req_o = 1'b1;
                if (tag_gnt_i) state_d = LOOKUP;
            end
            LOOKUP: begin
                tags_d  = tag_rdata_i;
                pend_d  = valid_i & dirty_i;
                state_d = ((valid_i & dirty_i) != '0) ? WB : INV;
            end
            WB: begin
                wb_valid_o = 1'b1;
                wb_way_o   = wb_way;
                wb_addr_o  = {tags_q[int'(wb_way)*TAG_WIDTH +: TAG_WIDTH], idx_q,
                              {OFFSET_WIDTH{1'b0}}};
                if (wb_ready_i) begin
                    pend_d = pend_q & ~way_oh;
                    if ((pend_q & ~way_oh) == '0) state_d = INV;
                end
            end
            INV: begin
                inv_o = 1'b1;
                // Completion by compare, so the counter never needs an extra bit to wrap into.
                if (idx_q == IDX_W'(NUM_SETS - 1)) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = READ;
                end
            end
            DONE: begin
                flush_ack_o = 1'b1;
                state_d     = DRAIN;
            end
            DRAIN: begin
                if (!flush_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o    = (state_q != IDLE);
    assign tag_idx_o = idx_q;

`ifdef DCACHE_FLUSH_STATS_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            flush_cnt_o <= '0;
            wb_cnt_o    <= '0;
        end else begin
            if (flush_ack_o)              flush_cnt_o <= flush_cnt_o + 32'd1;
            if (wb_valid_o && wb_ready_i) wb_cnt_o    <= wb_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_flush_unit.sv
// Scoreboard bench for dcache_flush_unit: a set/way model feeds the tag array, expected
// write-back/invalidate/ack events are queued per walk and popped as the DUT emits them.
module tb_dcache_flush_unit;

    localparam int NS = 4;
    localparam int NW = 2;
    localparam int TW = 12;
    localparam int OW = 4;
    localparam int IW = 2;
    localparam int WW = 1;
    localparam int AW = TW + IW + OW;

    typedef enum int {EV_WB, EV_INV, EV_ACK} ev_kind_e;
    typedef struct {
        ev_kind_e        kind;
        logic [AW-1:0]   addr;
        logic [WW-1:0]   way;
        logic [IW-1:0]   idx;
    } ev_t;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              flush_i = 1'b0;
    logic              flush_ack_o, busy_o, tag_req_o, wb_valid_o, inv_o;
    logic              tag_gnt_i = 1'b0;
    logic              wb_ready_i = 1'b0;
    logic [IW-1:0]     tag_idx_o;
    logic [NW*TW-1:0]  tag_rdata_i = '0;
    logic [NW-1:0]     valid_i = '0;
    logic [NW-1:0]     dirty_i = '0;
    logic [AW-1:0]     wb_addr_o;
    logic [WW-1:0]     wb_way_o;
`ifdef DCACHE_FLUSH_STATS_EN
    logic [31:0]       flush_cnt_o, wb_cnt_o;
`endif

    dcache_flush_unit #(
        .NUM_SETS(NS), .NUM_WAYS(NW), .TAG_WIDTH(TW), .OFFSET_WIDTH(OW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .flush_ack_o(flush_ack_o),
        .busy_o(busy_o), .tag_req_o(tag_req_o), .tag_gnt_i(tag_gnt_i),
        .tag_idx_o(tag_idx_o), .tag_rdata_i(tag_rdata_i), .valid_i(valid_i),
        .dirty_i(dirty_i), .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
        .wb_addr_o(wb_addr_o), .wb_way_o(wb_way_o), .inv_o(inv_o)
`ifdef DCACHE_FLUSH_STATS_EN
        , .flush_cnt_o(flush_cnt_o), .wb_cnt_o(wb_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int pcnt = 0;
    always @(posedge clk_i) pcnt <= pcnt + 1;

    // Cache contents seen by the array responder.
    logic [TW-1:0] m_tag [NS][NW];
    logic [NW-1:0] m_valid [NS];
    logic [NW-1:0] m_dirty [NS];

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  checks = 0, failures = 0;
    int  gnt_stall = 0, rdy_stall = 0;
    int  req_stall_cycles = 0, bp_cycles = 0;
    int  acks_seen = 0, ack_p = 0, accepts_total = 0;
    int  accept_p[$];
    int  walks_since_rst = 0, wbs_since_rst = 0;

    task automatic step();
        @(negedge clk_i);
        #1;
    endtask

    task automatic clear_model();
        for (int s = 0; s < NS; s++) begin
            m_valid[s] = '0;
            m_dirty[s] = '0;
            for (int w = 0; w < NW; w++) m_tag[s][w] = '0;
        end
    endtask

    task automatic push_walk();
        ev_t e;
        for (int s = 0; s < NS; s++) begin
            for (int w = 0; w < NW; w++) begin
                if (m_valid[s][w] && m_dirty[s][w]) begin
                    e.kind = EV_WB;
                    e.addr = (AW'(m_tag[s][w]) << (IW + OW)) | (AW'(s) << OW);
                    e.way  = WW'(w);
                    e.idx  = IW'(s);
                    exp_q.push_back(e);
                    wbs_since_rst++;
                end
            end
            e = '{kind: EV_INV, addr: '0, way: '0, idx: IW'(s)};
            exp_q.push_back(e);
        end
        e = '{kind: EV_ACK, addr: '0, way: '0, idx: '0};
        exp_q.push_back(e);
        walks_since_rst++;
    endtask

    // Array/write-back responder and event monitor, all at the falling edge.
    initial begin : responder
        bit            g_prev = 1'b0;
        logic [IW-1:0] g_idx = '0;
        bit            prev_stalled = 1'b0;
        logic [AW-1:0] prev_addr = '0;
        logic [WW-1:0] prev_way = '0;
        ev_t           o, e;
        forever begin
            @(negedge clk_i);
            if (g_prev) begin
                for (int w = 0; w < NW; w++) tag_rdata_i[w*TW +: TW] = m_tag[g_idx][w];
                valid_i = m_valid[g_idx];
                dirty_i = m_dirty[g_idx];
            end else begin
                tag_rdata_i = (NW*TW)'($urandom);
                valid_i = '1;
                dirty_i = '1;
            end
            tag_gnt_i = (gnt_stall == 0);
            if (tag_req_o && gnt_stall > 0) begin
                gnt_stall--;
                req_stall_cycles++;
            end
            g_prev = tag_req_o && tag_gnt_i;
            g_idx  = tag_idx_o;
            wb_ready_i = (rdy_stall == 0);
            if (wb_valid_o && rdy_stall > 0) begin
                rdy_stall--;
                bp_cycles++;
            end

            checks++;
            if ($countones({tag_req_o, wb_valid_o, inv_o}) > 1) begin
                failures++;
                $display("FAIL mutex: req=%b wb_valid=%b inv=%b, required at most one high",
                         tag_req_o, wb_valid_o, inv_o);
            end
            if (prev_stalled && wb_valid_o) begin
                checks++;
                if (wb_addr_o !== prev_addr || wb_way_o !== prev_way) begin
                    failures++;
                    $display("FAIL wb_stable: addr=%h way=%0d, required addr=%h way=%0d",
                             wb_addr_o, wb_way_o, prev_addr, prev_way);
                end
            end
            prev_stalled = wb_valid_o && !wb_ready_i;
            prev_addr    = wb_addr_o;
            prev_way     = wb_way_o;

            obs_q.delete();
            if (wb_valid_o && wb_ready_i) begin
                o = '{kind: EV_WB, addr: wb_addr_o, way: wb_way_o, idx: tag_idx_o};
                obs_q.push_back(o);
                accepts_total++;
                accept_p.push_back(pcnt);
            end
            if (inv_o) begin
                o = '{kind: EV_INV, addr: '0, way: '0, idx: tag_idx_o};
                obs_q.push_back(o);
            end
            if (flush_ack_o) begin
                o = '{kind: EV_ACK, addr: '0, way: '0, idx: '0};
                obs_q.push_back(o);
                acks_seen++;
                ack_p = pcnt;
            end
            foreach (obs_q[k]) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL scoreboard_extra: got %s idx=%0d addr=%h, required no event",
                             obs_q[k].kind.name(), obs_q[k].idx, obs_q[k].addr);
                end else begin
                    e = exp_q.pop_front();
                    if (obs_q[k].kind !== e.kind ||
                        (e.kind == EV_WB && (obs_q[k].addr !== e.addr || obs_q[k].way !== e.way)) ||
                        (e.kind == EV_INV && obs_q[k].idx !== e.idx)) begin
                        failures++;
                        $display("FAIL scoreboard: got %s idx=%0d addr=%h way=%0d, required %s idx=%0d addr=%h way=%0d",
                                 obs_q[k].kind.name(), obs_q[k].idx, obs_q[k].addr, obs_q[k].way,
                                 e.kind.name(), e.idx, e.addr, e.way);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst_i = 1'b1;
        flush_i = 1'b0;
        step();
        step();
        exp_q.delete();
        accept_p.delete();
        gnt_stall = 0;
        rdy_stall = 0;
        walks_since_rst = 0;
        wbs_since_rst = 0;
        rst_i = 1'b0;
        step();
    endtask

    // One full walk; hold_extra cycles of flush_i after the ack model the requester's drain.
    task automatic run_walk(input int hold_extra, output int p0);
        int a0;
        push_walk();
        flush_i = 1'b1;
        p0 = pcnt;
        a0 = acks_seen;
        for (int i = 0; i < 2000 && acks_seen == a0; i++) step();
        checks++;
        if (acks_seen == a0) begin
            failures++;
            $display("FAIL ack_timeout: acks=%0d, required %0d", acks_seen, a0 + 1);
        end
        for (int i = 0; i < hold_extra; i++) begin
            step();
            checks++;
            if (busy_o !== 1'b1 || tag_req_o !== 1'b0) begin
                failures++;
                $display("FAIL drain: busy=%b tag_req=%b, required busy=1 tag_req=0", busy_o, tag_req_o);
            end
        end
        flush_i = 1'b0;
        step();
        step();
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL return_idle: busy=%b, required 0", busy_o);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_left: pending=%0d, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        checks++;
        if ({flush_ack_o, busy_o, tag_req_o, wb_valid_o, inv_o} !== 5'b0) begin
            failures++;
            $display("FAIL %s_ctrl: ack/busy/req/wbv/inv=%b, required 00000", tag,
                     {flush_ack_o, busy_o, tag_req_o, wb_valid_o, inv_o});
        end
        checks++;
        if (tag_idx_o !== '0 || wb_addr_o !== '0 || wb_way_o !== '0) begin
            failures++;
            $display("FAIL %s_data: idx=%h addr=%h way=%h, required 0", tag,
                     tag_idx_o, wb_addr_o, wb_way_o);
        end
`ifdef DCACHE_FLUSH_STATS_EN
        checks++;
        if (flush_cnt_o !== 32'd0 || wb_cnt_o !== 32'd0) begin
            failures++;
            $display("FAIL %s_stats: flush_cnt=%0d wb_cnt=%0d, required 0", tag, flush_cnt_o, wb_cnt_o);
        end
`endif
    endtask

    task automatic test_reset();
        #1 rst_i = 1'b1;
        #2;
        check_outputs_zero("reset");
        do_reset();
        check_outputs_zero("post_reset");
    endtask

    task automatic test_clean();
        int p0, a0;
        clear_model();
        a0 = accepts_total;
        run_walk(1, p0);
        checks++;
        if (ack_p - p0 !== 3 * NS + 1) begin
            failures++;
            $display("FAIL clean_ack_cycle: got %0d, required %0d", ack_p - p0, 3 * NS + 1);
        end
        checks++;
        if (accepts_total - a0 !== 0) begin
            failures++;
            $display("FAIL clean_wb_count: got %0d, required 0", accepts_total - a0);
        end
    endtask

    task automatic load_set2_dirty();
        clear_model();
        m_valid[2] = 2'b11;
        m_dirty[2] = 2'b11;
        m_tag[2][0] = 12'h005;
        m_tag[2][1] = 12'h009;
    endtask

    task automatic test_dirty_ways();
        int p0;
        load_set2_dirty();
        accept_p.delete();
        run_walk(1, p0);
        checks++;
        if (accept_p.size() !== 2 || accept_p[1] - accept_p[0] !== 1) begin
            failures++;
            $display("FAIL dirty_back_to_back: accepts=%0d gap=%0d, required 2 and 1",
                     accept_p.size(), (accept_p.size() == 2) ? accept_p[1] - accept_p[0] : -1);
        end
    endtask

    task automatic test_backpressure();
        int p0, a0;
        load_set2_dirty();
        a0 = accepts_total;
        bp_cycles = 0;
        rdy_stall = 5;
        run_walk(1, p0);
        checks++;
        if (bp_cycles !== 5) begin
            failures++;
            $display("FAIL bp_cycles: got %0d, required 5", bp_cycles);
        end
        checks++;
        if (accepts_total - a0 !== 2) begin
            failures++;
            $display("FAIL bp_accepts: got %0d, required 2", accepts_total - a0);
        end
    endtask

    task automatic test_invalid_dirty();
        int p0, a0;
        clear_model();
        m_valid[1] = 2'b01;
        m_dirty[1] = 2'b10;
        m_tag[1][1] = 12'h3c3;
        a0 = accepts_total;
        run_walk(1, p0);
        checks++;
        if (accepts_total - a0 !== 0) begin
            failures++;
            $display("FAIL inv_dirty_wb: got %0d, required 0", accepts_total - a0);
        end
    endtask

    task automatic test_grant_protocol();
        int p0;
        do_reset();
        clear_model();
        m_valid[3] = 2'b10;
        m_dirty[3] = 2'b10;
        m_tag[3][1] = 12'habc;
        req_stall_cycles = 0;
        gnt_stall = 3;
        run_walk(1, p0);
        checks++;
        if (req_stall_cycles !== 3) begin
            failures++;
            $display("FAIL gnt_stall: req held %0d cycles without grant, required 3", req_stall_cycles);
        end
        repeat (3) step();
        run_walk(1, p0);
`ifdef DCACHE_FLUSH_STATS_EN
        checks++;
        if (flush_cnt_o !== 32'(walks_since_rst) || wb_cnt_o !== 32'(wbs_since_rst)) begin
            failures++;
            $display("FAIL stats: flush_cnt=%0d wb_cnt=%0d, required %0d and %0d",
                     flush_cnt_o, wb_cnt_o, walks_since_rst, wbs_since_rst);
        end
`endif
    endtask

    task automatic test_reset_mid_walk();
        int p0;
        bit hit;
        load_set2_dirty();
        rdy_stall = 1000;
        push_walk();
        flush_i = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            step();
            hit = wb_valid_o && tag_idx_o == 2'd2;
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL mid_reach_wb: wb at idx 2 not seen, required within 100 cycles");
        end
        #2 rst_i = 1'b1;
        #1;
        check_outputs_zero("mid_reset");
        flush_i = 1'b0;
        do_reset();
        run_walk(1, p0);
    endtask

    initial begin
        clear_model();
        test_reset();
        test_clean();
        test_dirty_ways();
        test_backpressure();
        test_invalid_dirty();
        test_grant_protocol();
        test_reset_mid_walk();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
